montgomery_ctrl: RTL and testbench

Sequencer that computes the radix-2 Montgomery product a·b·2^(−N) mod m. It issues every operation to the shared 514-bit multi-cycle adder through that adder's start/done handshake. It sits between the RSA exponentiation control and one adder instance. It holds the accumulator, bit counter and operand muxing, and performs no wide arithmetic itself. Every multiplication takes a fixed, data-independent number of adder operations, so timing is constant.

---
 rtl/montgomery_ctrl_if.sv | 33 +++
 rtl/montgomery_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_montgomery_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_ctrl_if.sv
// Bus between the Montgomery sequencer and the shared 514-bit multi-cycle adder.
// The sequencer is the master: it drives the operands and mode bits and
// pulses add_start. The adder is the slave: it returns add_result together
// with a one-cycle add_done.
interface montgomery_ctrl_if;
    logic         add_start;
    logic         add_subtract;
    logic         add_shift;
    logic [513:0] add_in_a;
    logic [513:0] add_in_b;
    logic [514:0] add_result;
    logic         add_done;

    modport master (
        output add_start,
        output add_subtract,
        output add_shift,
        output add_in_a,
        output add_in_b,
        input  add_result,
        input  add_done
    );

    modport slave (
        input  add_start,
        input  add_subtract,
        input  add_shift,
        input  add_in_a,
        input  add_in_b,
        output add_result,
        output add_done
    );
endinterface

// File: rtl/montgomery_ctrl.sv
// Radix-2 Montgomery product sequencer: result = a*b*2^(-N) mod m.
// All arithmetic is done by the external adder. This block only holds the
// operands, the accumulator C and the bit counter, and it selects the adder
// operands. Every bit issues both the add-B and the add-M-and-halve
// operation, even when the operand is zero, so the cycle count never
// depends on the data.
module montgomery_ctrl #(
    parameter int N = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy,
    montgomery_ctrl_if.master add_bus
);

    localparam int AW = 514;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_B,
        S_WAIT_B,
        S_ISSUE_M,
        S_WAIT_M,
        S_ISSUE_S,
        S_WAIT_S,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  m_reg;
    logic [AW-1:0] acc;
    logic [IW-1:0] idx;

    logic [AW-1:0] b_ext;
    logic [AW-1:0] m_ext;
    logic [N-1:0]  res_final;

    logic          go;
    logic          acc_ld;
    logic          idx_inc;
    logic          res_ld;
    logic          op_start;
    logic          op_sub;
    logic          op_shift;
    logic [AW-1:0] op_a;
    logic [AW-1:0] op_b;

    assign b_ext = {{(AW - N){1'b0}}, b_reg};
    assign m_ext = {{(AW - N){1'b0}}, m_reg};
    assign go    = (state == S_IDLE) && start;

    // Bit 514 of the subtraction is the borrow: C < m, so C is already reduced.
    assign res_final = add_bus.add_result[AW] ? acc[N-1:0] : add_bus.add_result[N-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and adder operand selection. Operands depend only on the
    // state pair (issue/wait) and on registers that change on add_done, so
    // they stay stable from add_start through the add_done cycle.
    always_comb begin
        state_nx = state;
        op_start = 1'b0;
        op_sub   = 1'b0;
        op_shift = 1'b0;
        op_a     = '0;
        op_b     = '0;
        done     = 1'b0;
        busy     = 1'b0;
        acc_ld   = 1'b0;
        idx_inc  = 1'b0;
        res_ld   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ISSUE_B;
                end
            end
            S_ISSUE_B, S_WAIT_B: begin
                busy = 1'b1;
                op_a = acc;
                op_b = a_reg[idx] ? b_ext : '0;
                if (state == S_ISSUE_B) begin
                    op_start = 1'b1;
                    state_nx = S_WAIT_B;
                end else if (add_bus.add_done) begin
                    acc_ld   = 1'b1;
                    state_nx = S_ISSUE_M;
                end
            end
            S_ISSUE_M, S_WAIT_M: begin
                busy     = 1'b1;
                op_shift = 1'b1;
                op_a     = acc;
                op_b     = acc[0] ? m_ext : '0;
                if (state == S_ISSUE_M) begin
                    op_start = 1'b1;
                    state_nx = S_WAIT_M;
                end else if (add_bus.add_done) begin
                    acc_ld = 1'b1;
                    if (idx == LAST) begin
                        state_nx = S_ISSUE_S;
                    end else begin
                        idx_inc  = 1'b1;
                        state_nx = S_ISSUE_B;
                    end
                end
            end
            S_ISSUE_S, S_WAIT_S: begin
                busy   = 1'b1;
                op_sub = 1'b1;
                op_a   = acc;
                op_b   = m_ext;
                if (state == S_ISSUE_S) begin
                    op_start = 1'b1;
                    state_nx = S_WAIT_S;
                end else if (add_bus.add_done) begin
                    res_ld   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign add_bus.add_start    = op_start;
    assign add_bus.add_subtract = op_sub;
    assign add_bus.add_shift    = op_shift;
    assign add_bus.add_in_a     = op_a;
    assign add_bus.add_in_b     = op_b;

    // Operand capture on an accepted start; operands need no reset.
    always_ff @(posedge clk) begin
        if (go) begin
            a_reg <= in_a;
            b_reg <= in_b;
            m_reg <= in_m;
        end
    end

    // Accumulator, bit counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            if (go) begin
                acc <= '0;
                idx <= '0;
            end else begin
                if (acc_ld) begin
                    acc <= add_bus.add_result[AW-1:0];
                end
                if (idx_inc) begin
                    idx <= idx + 1'b1;
                end
            end
            if (res_ld) begin
                result <= res_final;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_ctrl.sv
// Bench for montgomery_ctrl: one N=8 and one N=512 instance, each driving a
// behavioural adder (done 4 cycles after start, 5 with shift). Results are
// compared with a reference that reduces the full product a*b mod m and then
// divides by 2 modulo m, N times.
module tb_montgomery_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_s, start_w;
    logic [7:0]   a_s, b_s, m_s, res_s;
    logic [511:0] a_w, b_w, m_w, res_w;
    logic         done_s, busy_s, done_w, busy_w;

    int n_chk = 0;
    int n_err = 0;

    montgomery_ctrl_if bus_s ();
    montgomery_ctrl_if bus_w ();

    montgomery_ctrl #(.N(8)) dut_s (
        .clk(clk), .reset(rst), .start(start_s),
        .in_a(a_s), .in_b(b_s), .in_m(m_s),
        .result(res_s), .done(done_s), .busy(busy_s), .add_bus(bus_s)
    );

    montgomery_ctrl #(.N(512)) dut_w (
        .clk(clk), .reset(rst), .start(start_w),
        .in_a(a_w), .in_b(b_w), .in_m(m_w),
        .result(res_w), .done(done_w), .busy(busy_w), .add_bus(bus_w)
    );

    logic         st[2], sb[2], sh[2], dn_a[2];
    logic [513:0] ia[2], ib[2];
    logic [514:0] ar[2];
    int           starts_c[2], stab_c[2], ovl_c[2];

    assign st[0] = bus_s.add_start;
    assign sb[0] = bus_s.add_subtract;
    assign sh[0] = bus_s.add_shift;
    assign ia[0] = bus_s.add_in_a;
    assign ib[0] = bus_s.add_in_b;
    assign bus_s.add_result = ar[0];
    assign bus_s.add_done   = dn_a[0];

    assign st[1] = bus_w.add_start;
    assign sb[1] = bus_w.add_subtract;
    assign sh[1] = bus_w.add_shift;
    assign ia[1] = bus_w.add_in_a;
    assign ib[1] = bus_w.add_in_b;
    assign bus_w.add_result = ar[1];
    assign bus_w.add_done   = dn_a[1];

    // Behavioural adder; it is deliberately not reset so that an in-flight
    // completion reaches the controller after a reset. add_result is random
    // outside the done cycle.
    for (genvar g = 0; g < 2; g++) begin : g_adder
        int           n_starts = 0;
        int           n_stab   = 0;
        int           n_ovl    = 0;
        int           cnt      = 0;
        logic         track    = 1'b0;
        logic         dn       = 1'b0;
        logic [513:0] la       = '0;
        logic [513:0] lb       = '0;
        logic         lsub     = 1'b0;
        logic         lshift   = 1'b0;
        logic [514:0] res      = '0;
        logic [543:0] junk     = '0;

        always @(posedge clk) begin
            for (int k = 0; k < 17; k++) junk[k*32 +: 32] <= $urandom();
            dn <= 1'b0;
            if ((cnt != 0 || dn) && track && !st[g] &&
                ({ia[g], ib[g], sh[g], sb[g]} != {la, lb, lshift, lsub}))
                n_stab <= n_stab + 1;
            if (st[g]) begin
                n_starts <= n_starts + 1;
                if (cnt != 0 || dn) n_ovl <= n_ovl + 1;
                la     <= ia[g];
                lb     <= ib[g];
                lsub   <= sb[g];
                lshift <= sh[g];
                track  <= !rst;
                cnt    <= sh[g] ? 4 : 3;
                if (sb[g])      res <= {1'b0, ia[g]} - {1'b0, ib[g]};
                else if (sh[g]) res <= ({1'b0, ia[g]} + {1'b0, ib[g]}) >> 1;
                else            res <= {1'b0, ia[g]} + {1'b0, ib[g]};
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end else if (cnt == 1) begin
                cnt <= 0;
                dn  <= 1'b1;
            end
            if (rst) track <= 1'b0;
        end

        assign ar[g]       = dn ? res : junk[514:0];
        assign dn_a[g]     = dn;
        assign starts_c[g] = n_starts;
        assign stab_c[g]   = n_stab;
        assign ovl_c[g]    = n_ovl;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                              input logic [511:0] m, input int n);
        logic [1023:0] x;
        x = ({512'b0, a} * {512'b0, b}) % {512'b0, m};
        for (int k = 0; k < n; k++) x = x[0] ? (x + {512'b0, m}) >> 1 : x >> 1;
        return x[511:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic cur_done(input int s);
        return (s == 0) ? done_s : done_w;
    endfunction

    function automatic logic cur_busy(input int s);
        return (s == 0) ? busy_s : busy_w;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_s = v;
        else        start_w = v;
    endtask

    // One multiplication: start is high during cycle 0; lat is the cycle in
    // which done is seen. inj pulses start again at cycles 1, 50 and 93.
    task automatic run_mul(input int s, input logic [511:0] a, input logic [511:0] b,
                           input logic [511:0] m, input bit inj,
                           output logic [511:0] res, output int lat,
                           output int busy_n, output int nst);
        int s0;
        int lim;
        lim = (s == 0) ? 300 : 6000;
        s0  = starts_c[s];
        @(negedge clk);
        if (s == 0) begin
            a_s = a[7:0];
            b_s = b[7:0];
            m_s = m[7:0];
        end else begin
            a_w = a;
            b_w = b;
            m_w = m;
        end
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        lat    = 1;
        busy_n = 0;
        while (!cur_done(s) && lat < lim) begin
            if (cur_busy(s)) busy_n++;
            if (inj && (lat == 1 || lat == 50 || lat == 93)) set_start(s, 1'b1);
            @(negedge clk);
            set_start(s, 1'b0);
            lat++;
        end
        check_eq("busy_at_done", 512'(cur_busy(s)), 512'(0));
        res = (s == 0) ? 512'(res_s) : res_w;
        nst = starts_c[s] - s0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] r, ma, mb, mm;
        int lat, bn, ns, ex, cyc;

        rst = 1'b1;
        start_s = 1'b0; start_w = 1'b0;
        a_s = '0; b_s = '0; m_s = '0;
        a_w = '0; b_w = '0; m_w = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",     512'(busy_s), 512'(0));
        check_eq("rst_done",     512'(done_s), 512'(0));
        check_eq("rst_result",   512'(res_s),  512'(0));
        check_eq("rst_add_start", 512'(bus_s.add_start), 512'(0));
        check_eq("rst_add_sub",  512'(bus_s.add_subtract), 512'(0));
        check_eq("rst_add_shift", 512'(bus_s.add_shift), 512'(0));
        check_eq("rst_add_in_a", 512'(bus_s.add_in_a), 512'(0));
        check_eq("rst_add_in_b", 512'(bus_s.add_in_b), 512'(0));
        check_eq("rst_w_busy",   512'(busy_w), 512'(0));
        check_eq("rst_w_result", res_w, 512'(0));
        rst = 1'b0;

        run_mul(0, 512'(5), 512'(7), 512'(13), 1'b0, r, lat, bn, ns);
        check_eq("p1_result", r, 512'(1));
        check_eq("p1_latency", 512'(lat), 512'(94));
        check_eq("p1_busy_cycles", 512'(bn), 512'(93));
        check_eq("p1_add_starts", 512'(ns), 512'(17));

        run_mul(0, 512'(1), 512'(1), 512'(13), 1'b0, r, lat, bn, ns);
        check_eq("p2_result", r, 512'(3));

        run_mul(0, 512'(0), 512'(12), 512'(13), 1'b0, r, lat, bn, ns);
        check_eq("p3_result", r, 512'(0));
        check_eq("p3_add_starts", 512'(ns), 512'(17));
        check_eq("p3_latency", 512'(lat), 512'(94));

        run_mul(0, 512'(254), 512'(254), 512'(255), 1'b0, r, lat, bn, ns);
        check_eq("noborrow_result", r, 512'(1));
        run_mul(0, 512'(1), 512'(1), 512'(255), 1'b0, r, lat, bn, ns);
        check_eq("borrow_result", r, 512'(1));

        // start pulses while busy must be ignored
        run_mul(0, 512'(5), 512'(7), 512'(13), 1'b1, r, lat, bn, ns);
        check_eq("inj_result", r, 512'(1));
        check_eq("inj_latency", 512'(lat), 512'(94));
        check_eq("inj_add_starts", 512'(ns), 512'(17));
        ex = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_s || busy_s) ex++;
        end
        check_eq("inj_extra_activity", 512'(ex), 512'(0));

        // reset at cycle 40 of a run, new start at cycle 45
        @(negedge clk);
        a_s = 8'd5; b_s = 8'd7; m_s = 8'd13;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        cyc++;
        check_eq("abort_busy",      512'(busy_s), 512'(0));
        check_eq("abort_done",      512'(done_s), 512'(0));
        check_eq("abort_result",    512'(res_s), 512'(0));
        check_eq("abort_add_start", 512'(bus_s.add_start), 512'(0));
        check_eq("abort_add_in_a",  512'(bus_s.add_in_a), 512'(0));
        check_eq("abort_add_shift", 512'(bus_s.add_shift), 512'(0));
        rst = 1'b0;
        ex = 0;
        while (cyc < 44) begin
            @(negedge clk);
            cyc++;
            if (done_s || busy_s) ex++;
        end
        check_eq("abort_no_done", 512'(ex), 512'(0));
        run_mul(0, 512'(5), 512'(7), 512'(13), 1'b0, r, lat, bn, ns);
        check_eq("restart_result", r, 512'(1));
        check_eq("restart_latency", 512'(lat), 512'(94));

        // random N=8
        for (int t = 0; t < 20; t++) begin
            mm = 512'($urandom_range(1, 127) * 2 + 1);
            ma = 512'($urandom_range(0, 32'(mm[7:0]) - 1));
            mb = 512'($urandom_range(0, 32'(mm[7:0]) - 1));
            run_mul(0, ma, mb, mm, 1'b0, r, lat, bn, ns);
            check_eq("rnd8_result", r, mont_ref(ma, mb, mm, 8));
            check_eq("rnd8_add_starts", 512'(ns), 512'(17));
            check_eq("rnd8_latency", 512'(lat), 512'(94));
        end

        // random N=512
        for (int t = 0; t < 3; t++) begin
            mm = rand512();
            mm[0] = 1'b1;
            mm[511] = 1'b1;
            ma = rand512() % mm;
            mb = rand512() % mm;
            run_mul(1, ma, mb, mm, 1'b0, r, lat, bn, ns);
            check_eq("rnd512_result", r, mont_ref(ma, mb, mm, 512));
            check_eq("rnd512_add_starts", 512'(ns), 512'(1025));
            check_eq("rnd512_latency", 512'(lat), 512'(5638));
        end

        repeat (8) @(negedge clk);
        check_eq("stable_ops_n8",   512'(stab_c[0]), 512'(0));
        check_eq("stable_ops_n512", 512'(stab_c[1]), 512'(0));
        check_eq("no_overlap_n8",   512'(ovl_c[0]), 512'(0));
        check_eq("no_overlap_n512", 512'(ovl_c[1]), 512'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
